// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per clock, LSB first.
// A single borrow flop ripples between bit slices across cycles; valid/ready
// handshakes on both sides let it sit in a chained arithmetic datapath.

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrowout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             bw;
   logic [CW-1:0]    cnt;

   logic             d;
   logic             bw_next;
   logic [WIDTH-1:0] res_next;

   // Operands are only accepted while idle; this is the upstream back-pressure.
   assign in_ready = (state == IDLE);

   // One full-subtractor slice on the current LSBs plus the running borrow.
   always_comb begin
      d        = a_sh[0] ^ b_sh[0] ^ bw;
      bw_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
      res_next = {d, res_sh[WIDTH-1:1]};
   end

   // Handshake FSM plus the serial datapath: capture, shift WIDTH times, hold.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         res_sh    <= '0;
         bw        <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         diff      <= '0;
         borrowout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  res_sh <= '0;
                  bw     <= 1'b0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               res_sh <= res_next;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               bw     <= bw_next;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  diff      <= res_next;
                  borrowout <= bw_next;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor,
// an 8-bit instance for the main scenarios and a 4-bit instance for the
// parameter check.

module tb_serial_subtractor;

   logic       clock = 1'b0;
   logic       reset_n;

   logic       in_valid, in_ready, out_valid, out_ready, borrowout;
   logic [7:0] a, b, diff;

   logic       in_valid4, in_ready4, out_valid4, out_ready4, borrowout4;
   logic [3:0] a4, b4, diff4;

   int checks = 0;
   int passes = 0;

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   serial_subtractor #(.WIDTH(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrowout(borrowout)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .diff(diff4), .borrowout(borrowout4)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Present one operand pair on the 8-bit instance, then count edges until out_valid.
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, output int lat);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clock); #1;
         k++;
      end
      a = av; b = bv; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   // Directed scenarios in sequence.
   initial begin
      int lat;
      logic [7:0] wa [3];
      logic [7:0] wb [3];
      logic [7:0] wd [3];
      logic       wbo [3];
      logic [7:0] qa [$];
      logic [7:0] qb [$];
      int sent, got;
      logic acc, cons;
      logic [7:0] ea, eb;

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;

      // Reset state
      #12;
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_diff", diff, 0);
      checkOutput("rst_borrow", borrowout, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Basic: 0x50 - 0x20
      out_ready = 1'b1;
      applyStimulus(8'h50, 8'h20, lat);
      checkOutput("basic_latency", lat, 8);
      checkOutput("basic_diff", diff, 8'h30);
      checkOutput("basic_borrow", borrowout, 0);
      checkOutput("basic_in_ready_busy", in_ready, 0);
      @(posedge clock); #1;
      checkOutput("basic_out_valid_drop", out_valid, 0);
      checkOutput("basic_in_ready_back", in_ready, 1);
      checkOutput("basic_diff_held", diff, 8'h30);

      // Wrap and equality cases
      wa = '{8'h00, 8'hFF, 8'h00};
      wb = '{8'h01, 8'hFF, 8'hFF};
      wd = '{8'hFF, 8'h00, 8'h01};
      wbo = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(wa[i], wb[i], lat);
         checkOutput($sformatf("wrap%0d_latency", i), lat, 8);
         checkOutput($sformatf("wrap%0d_diff", i), diff, wd[i]);
         checkOutput($sformatf("wrap%0d_borrow", i), borrowout, wbo[i]);
         @(posedge clock); #1;
      end

      // Backpressure with a distracting input during the wait
      out_ready = 1'b0;
      applyStimulus(8'h9C, 8'h3A, lat);
      checkOutput("bp_latency", lat, 8);
      in_valid = 1'b1; a = 8'h11; b = 8'h22;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp_hold%0d_valid", i), out_valid, 1);
         checkOutput($sformatf("bp_hold%0d_diff", i), diff, 8'h62);
         checkOutput($sformatf("bp_hold%0d_borrow", i), borrowout, 0);
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      checkOutput("bp_release_valid", out_valid, 0);
      checkOutput("bp_release_diff", diff, 8'h62);
      checkOutput("bp_release_in_ready", in_ready, 1);

      // Reset mid-RUN
      a = 8'h80; b = 8'h01; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      checkOutput("midrst_busy", in_ready, 0);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_diff", diff, 0);
      checkOutput("midrst_borrow", borrowout, 0);
      checkOutput("midrst_in_ready", in_ready, 1);
      @(posedge clock); #1;
      @(posedge clock); #1;
      checkOutput("midrst_no_pulse", out_valid, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      applyStimulus(8'h05, 8'h07, lat);
      checkOutput("postrst_latency", lat, 8);
      checkOutput("postrst_diff", diff, 8'hFE);
      checkOutput("postrst_borrow", borrowout, 1);
      @(posedge clock); #1;

      // Back-to-back with random out_ready against a reference model
      sent = 0; got = 0;
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      for (int cyc = 0; cyc < 2000 && got < 16; cyc++) begin
         out_ready = 1'($urandom_range(0, 1));
         acc  = in_ready && in_valid;
         cons = out_valid && out_ready;
         if (cons) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            checkOutput($sformatf("b2b%0d_diff", got), diff, 8'(ea - eb));
            checkOutput($sformatf("b2b%0d_borrow", got), borrowout, (ea < eb) ? 1 : 0);
            got++;
         end
         if (acc) begin
            qa.push_back(a);
            qb.push_back(b);
            sent++;
         end
         @(posedge clock); #1;
         if (acc) begin
            if (sent < 16) begin
               a = 8'($urandom); b = 8'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      checkOutput("b2b_result_count", got, 16);
      checkOutput("b2b_accept_count", sent, 16);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clock); #1;

      // WIDTH=4 instance: 0x3 - 0x5
      out_ready4 = 1'b1;
      a4 = 4'h3; b4 = 4'h5; in_valid4 = 1'b1;
      @(posedge clock); #1;
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 50) begin
         @(posedge clock); #1;
         lat++;
      end
      checkOutput("w4_latency", lat, 4);
      checkOutput("w4_diff", diff4, 4'hE);
      checkOutput("w4_borrow", borrowout4, 1);
      @(posedge clock); #1;
      checkOutput("w4_in_ready_back", in_ready4, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
